// File: rtl/otter_icache_pkg.sv
// Shared types and constants for the OTTER N-way instruction cache.
//   state_e : refill controller states
//   NOP     : instruction returned whenever the cache has no valid word to offer
package otter_icache_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StFill,
      StUpdate
   } state_e;

   localparam logic [31:0] NOP = 32'h00000013;  // addi x0, x0, 0

endpackage

// File: rtl/otter_icache_nway_if.sv
// Bus bundle between the fetch stage / backing memory and the instruction cache.
//   pc, rden, invalidate        : fetch side requests
//   instr, hit, stall           : fetch side results
//   mem_req, mem_addr           : refill request toward instruction memory
//   mem_ack, mem_rvalid, mem_rdata : memory acceptance and refill beats
//   hit_cnt, miss_cnt           : performance counters
// The cache uses the slave modport; the environment (core + memory) uses master.
interface otter_icache_nway_if #(
   parameter int unsigned ADDR_W = 32
);
   logic [ADDR_W-1:0] pc;
   logic              rden;
   logic              invalidate;
   logic [31:0]       instr;
   logic              hit;
   logic              stall;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;
   logic [31:0]       hit_cnt;
   logic [31:0]       miss_cnt;

   modport slave (
      input  pc, rden, invalidate, mem_ack, mem_rvalid, mem_rdata,
      output instr, hit, stall, mem_req, mem_addr, hit_cnt, miss_cnt
   );

   modport master (
      output pc, rden, invalidate, mem_ack, mem_rvalid, mem_rdata,
      input  instr, hit, stall, mem_req, mem_addr, hit_cnt, miss_cnt
   );
endinterface

// File: rtl/icache_plru.sv
// Tree pseudo-LRU helper for one cache set. Purely combinational.
//   bits       : current PLRU tree bits of the set (heap order, node 0 = root)
//   access_way : way being touched (hit or refill)
//   victim     : way the tree currently points at for replacement
//   next_bits  : tree bits after marking access_way most-recent
// A node bit of 0 steers the victim toward the lower-numbered half.
module icache_plru #(
   parameter int unsigned WAYS = 2,
   localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
   localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1
) (
   input  logic [PLRU_W-1:0] bits,
   input  logic [WAY_W-1:0]  access_way,
   output logic [WAY_W-1:0]  victim,
   output logic [PLRU_W-1:0] next_bits
);
   localparam int unsigned LVL = $clog2(WAYS);

   always_comb begin
      int unsigned       node;
      logic [PLRU_W-1:0] sh;
      logic              b;
      victim = '0;
      node   = 0;
      sh     = '0;
      b      = 1'b0;
      for (int l = 0; l < int'(LVL); l++) begin
         sh     = bits >> node;
         b      = sh[0];
         victim = (victim << 1) | WAY_W'(b);
         node   = 2 * node + 1 + 32'(b);
      end
   end

   // Walk the accessed way's path and point every node away from it.
   always_comb begin
      int unsigned      node;
      logic [WAY_W-1:0] ash;
      logic             dir;
      next_bits = bits;
      node      = 0;
      ash       = '0;
      dir       = 1'b0;
      for (int l = 0; l < int'(LVL); l++) begin
         ash       = access_way >> (int'(LVL) - 1 - l);
         dir       = ash[0];
         next_bits = (next_bits & ~(PLRU_W'(1) << node)) | (PLRU_W'(~dir) << node);
         node      = 2 * node + 1 + 32'(dir);
      end
   end
endmodule

// File: rtl/otter_icache_nway.sv
// N-way set-associative instruction cache for the OTTER fetch path.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of otter_icache_nway_if (fetch request/result, refill
//           handshake to backing memory, hit/miss counters)
// Hits return data in the same cycle. A miss latches the line address and a
// victim way, requests the line, accepts LINE_WORDS beats, then writes the tag
// and returns to IDLE where the current PC is looked up again.
module otter_icache_nway
   import otter_icache_pkg::*;
#(
   parameter int unsigned WAYS       = 2,
   parameter int unsigned SETS       = 16,
   parameter int unsigned LINE_WORDS = 8,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   otter_icache_nway_if.slave bus
);
   localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
   localparam int unsigned IDX_W  = $clog2(SETS);
   localparam int unsigned TAG_W  = ADDR_W - 2 - OFF_W - IDX_W;
   localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

   // Storage; data and tags carry no reset, validity is tracked separately.
   logic [31:0]      data_mem [WAYS][SETS][LINE_WORDS];
   logic [TAG_W-1:0] tag_mem  [WAYS][SETS];

   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAYS-1:0]   valid_d [SETS];
   logic [PLRU_W-1:0] plru_q  [SETS];
   logic [PLRU_W-1:0] plru_d  [SETS];

   state_e           state_q, state_d;
   logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
   logic [IDX_W-1:0] miss_idx_q, miss_idx_d;
   logic [WAY_W-1:0] victim_q, victim_d;
   logic [OFF_W-1:0] beat_q, beat_d;
   logic             pend_q, pend_d;
   logic [31:0]      hit_cnt_q, hit_cnt_d;
   logic [31:0]      miss_cnt_q, miss_cnt_d;

   logic [OFF_W-1:0] offset;
   logic [IDX_W-1:0] index;
   logic [TAG_W-1:0] tag;
   logic             unused_pc;

   assign offset    = bus.pc[OFF_W+1:2];
   assign index     = bus.pc[OFF_W+IDX_W+1:OFF_W+2];
   assign tag       = bus.pc[ADDR_W-1:ADDR_W-TAG_W];
   assign unused_pc = ^bus.pc[1:0];

   // Tag compare across all ways of the addressed set.
   logic [WAYS-1:0]  way_hit;
   logic [WAY_W-1:0] hit_way;
   logic             lookup_hit;
   logic             idle;
   logic             hit;

   always_comb begin
      way_hit = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
         way_hit[w] = valid_q[index][w] && (tag_mem[w][index] == tag);
      end
   end

   always_comb begin
      hit_way = '0;
      for (int w = int'(WAYS) - 1; w >= 0; w--) begin
         if (way_hit[w]) hit_way = WAY_W'(w);
      end
   end

   assign lookup_hit = |way_hit;
   assign idle       = (state_q == StIdle);
   assign hit        = bus.rden && idle && lookup_hit;

   // Lowest-numbered invalid way takes priority over the PLRU choice.
   logic [WAY_W-1:0] inv_way;
   logic             any_inv;

   always_comb begin
      inv_way = '0;
      any_inv = 1'b0;
      for (int w = int'(WAYS) - 1; w >= 0; w--) begin
         if (!valid_q[index][w]) begin
            inv_way = WAY_W'(w);
            any_inv = 1'b1;
         end
      end
   end

   // One PLRU instance: IDLE looks at the fetch set, UPDATE at the refilled set.
   logic [IDX_W-1:0]  plru_idx;
   logic [WAY_W-1:0]  plru_acc;
   logic [WAY_W-1:0]  plru_victim;
   logic [PLRU_W-1:0] plru_next;

   assign plru_idx = (state_q == StUpdate) ? miss_idx_q : index;
   assign plru_acc = (state_q == StUpdate) ? victim_q : hit_way;

   icache_plru #(
      .WAYS (WAYS)
   ) u_plru (
      .bits       (plru_q[plru_idx]),
      .access_way (plru_acc),
      .victim     (plru_victim),
      .next_bits  (plru_next)
   );

   logic fill_we;
   logic tag_we;

   always_comb begin
      state_d    = state_q;
      miss_tag_d = miss_tag_q;
      miss_idx_d = miss_idx_q;
      victim_d   = victim_q;
      beat_d     = beat_q;
      pend_d     = pend_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      valid_d    = valid_q;
      plru_d     = plru_q;
      fill_we    = 1'b0;
      tag_we     = 1'b0;

      unique case (state_q)
         StIdle: begin
            // This cycle's lookup already used the old valid bits.
            if (bus.invalidate) begin
               for (int s = 0; s < int'(SETS); s++) valid_d[s] = '0;
            end
            if (hit) begin
               plru_d[index] = plru_next;
               hit_cnt_d     = hit_cnt_q + 32'd1;
            end else if (bus.rden) begin
               state_d    = StReq;
               miss_tag_d = tag;
               miss_idx_d = index;
               victim_d   = any_inv ? inv_way : plru_victim;
               miss_cnt_d = miss_cnt_q + 32'd1;
            end
         end
         StReq: begin
            pend_d = pend_q | bus.invalidate;
            if (bus.mem_ack) state_d = StFill;
         end
         StFill: begin
            pend_d = pend_q | bus.invalidate;
            if (bus.mem_rvalid) begin
               fill_we = 1'b1;
               beat_d  = beat_q + 1'b1;
               if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
                  state_d = StUpdate;
                  beat_d  = '0;
               end
            end
         end
         StUpdate: begin
            tag_we                       = 1'b1;
            valid_d[miss_idx_q][victim_q] = 1'b1;
            plru_d[miss_idx_q]           = plru_next;
            // A deferred invalidate also discards the line just installed.
            if (pend_q || bus.invalidate) begin
               for (int s = 0; s < int'(SETS); s++) valid_d[s] = '0;
            end
            pend_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         miss_tag_q <= '0;
         miss_idx_q <= '0;
         victim_q   <= '0;
         beat_q     <= '0;
         pend_q     <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         for (int s = 0; s < int'(SETS); s++) begin
            valid_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         state_q    <= state_d;
         miss_tag_q <= miss_tag_d;
         miss_idx_q <= miss_idx_d;
         victim_q   <= victim_d;
         beat_q     <= beat_d;
         pend_q     <= pend_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         valid_q    <= valid_d;
         plru_q     <= plru_d;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_we) data_mem[victim_q][miss_idx_q][beat_q] <= bus.mem_rdata;
      if (tag_we)  tag_mem[victim_q][miss_idx_q]          <= miss_tag_q;
   end

   assign bus.hit      = hit;
   assign bus.instr    = hit ? data_mem[hit_way][index][offset] : NOP;
   assign bus.stall    = (idle && bus.rden && !lookup_hit) || !idle;
   assign bus.mem_req  = (state_q == StReq);
   assign bus.mem_addr = (state_q == StReq) ? {miss_tag_q, miss_idx_q, {(OFF_W + 2){1'b0}}} : '0;
   assign bus.hit_cnt  = hit_cnt_q;
   assign bus.miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_otter_icache_nway.sv
// Self-checking bench for otter_icache_nway (default parameters: 2 ways,
// 16 sets, 8-word lines). The bench plays the backing memory and keeps a
// reference model of tags, validity and recency per set; with two ways the
// tree PLRU evicts the least recently used way.
module tb_otter_icache_nway;

   localparam logic [31:0] EXP_NOP = 32'h00000013;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   otter_icache_nway_if #(.ADDR_W(32)) bus ();

   otter_icache_nway #(
      .WAYS       (2),
      .SETS       (16),
      .LINE_WORDS (8),
      .ADDR_W     (32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Backing memory contents: the first line holds 0xA0..0xA7.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      w = a & ~32'h3;
      if (w < 32'h20) return 32'hA0 + (w >> 2);
      return (w * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   // Reference model state.
   bit m_valid [16][2];
   int m_tag   [16][2];
   int m_use   [16][2];
   int stamp;
   int m_hits, m_misses;
   bit m_pend;
   int m_set, m_vtag, m_victim;

   task automatic model_reset();
      for (int s = 0; s < 16; s++) begin
         for (int w = 0; w < 2; w++) begin
            m_valid[s][w] = 1'b0;
            m_use[s][w]   = 0;
         end
      end
      stamp    = 0;
      m_hits   = 0;
      m_misses = 0;
      m_pend   = 1'b0;
   endtask

   task automatic model_clear_valid();
      for (int s = 0; s < 16; s++) begin
         m_valid[s][0] = 1'b0;
         m_valid[s][1] = 1'b0;
      end
   endtask

   function automatic int m_lookup(input logic [31:0] pc);
      int s;
      int tg;
      s  = int'((pc >> 5) & 32'hF);
      tg = int'(pc >> 9);
      for (int w = 0; w < 2; w++) begin
         if (m_valid[s][w] && m_tag[s][w] == tg) return w;
      end
      return -1;
   endfunction

   function automatic logic [31:0] rand_pc();
      logic [31:0] t, ix, off, lo;
      t   = $urandom_range(0, 3);
      ix  = $urandom_range(0, 3);
      off = $urandom_range(0, 7);
      lo  = $urandom_range(0, 3);
      return (t << 9) | (ix << 5) | (off << 2) | lo;
   endfunction

   // One cycle with the cache expected in IDLE. Entered and left at posedge+1.
   task automatic drive_idle(input logic [31:0] pc, input bit rd, input bit inv, output bit missed);
      int  s;
      int  way;
      bit  exp_hit;
      s               = int'((pc >> 5) & 32'hF);
      way             = m_lookup(pc);
      bus.pc          = pc;
      bus.rden        = rd;
      bus.invalidate  = inv;
      bus.mem_ack     = 1'b0;
      bus.mem_rvalid  = 1'($urandom_range(0, 1));
      bus.mem_rdata   = $urandom;
      exp_hit         = rd && (way >= 0);
      missed          = rd && (way < 0);
      @(negedge clk);
      check_val("idle_hit", 32'(bus.hit), 32'(exp_hit));
      check_val("idle_stall", 32'(bus.stall), 32'(missed));
      check_val("idle_instr", bus.instr, exp_hit ? mem_word(pc) : EXP_NOP);
      check_val("idle_mem_req", 32'(bus.mem_req), 32'd0);
      check_val("idle_hit_cnt", bus.hit_cnt, 32'(m_hits));
      check_val("idle_miss_cnt", bus.miss_cnt, 32'(m_misses));
      if (exp_hit) begin
         stamp++;
         m_use[s][way] = stamp;
         m_hits++;
      end
      if (missed) begin
         m_set  = s;
         m_vtag = int'(pc >> 9);
         if (!m_valid[s][0])      m_victim = 0;
         else if (!m_valid[s][1]) m_victim = 1;
         else                     m_victim = (m_use[s][0] < m_use[s][1]) ? 0 : 1;
         m_misses++;
      end
      @(posedge clk);
      #1;
      if (inv) model_clear_valid();
      bus.invalidate = 1'b0;
   endtask

   task automatic do_reset();
      bus.rden       = 1'b0;
      bus.invalidate = 1'b0;
      bus.mem_ack    = 1'b0;
      bus.mem_rvalid = 1'b0;
      rst_n          = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   // Serve the refill for the line latched by the last drive_idle miss.
   task automatic refill(input int ack_dly, input int gap, input int inv_beat, input int rst_beat,
                         input bit rnd_inv, output bit aborted);
      logic [31:0] base;
      bit          inv;
      int          g;
      base    = (32'(m_vtag) << 9) | (32'(m_set) << 5);
      aborted = 1'b0;
      m_pend  = 1'b0;
      for (int i = 0; i <= ack_dly; i++) begin
         bus.mem_ack    = (i == ack_dly);
         bus.pc         = rand_pc();
         bus.rden       = 1'($urandom_range(0, 1));
         bus.mem_rvalid = 1'($urandom_range(0, 1));
         bus.mem_rdata  = $urandom;
         inv            = rnd_inv && ($urandom_range(0, 15) == 0);
         bus.invalidate = inv;
         @(negedge clk);
         check_val("req_mem_req", 32'(bus.mem_req), 32'd1);
         check_val("req_mem_addr", bus.mem_addr, base);
         check_val("req_stall", 32'(bus.stall), 32'd1);
         check_val("req_hit", 32'(bus.hit), 32'd0);
         @(posedge clk);
         #1;
         m_pend = m_pend | inv;
      end
      bus.mem_ack = 1'b0;
      for (int b = 0; b < 8; b++) begin
         g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
         for (int k = 0; k < g; k++) begin
            bus.mem_rvalid = 1'b0;
            bus.pc         = rand_pc();
            inv            = rnd_inv && ($urandom_range(0, 15) == 0);
            bus.invalidate = inv;
            @(negedge clk);
            check_val("gap_mem_req", 32'(bus.mem_req), 32'd0);
            check_val("gap_stall", 32'(bus.stall), 32'd1);
            @(posedge clk);
            #1;
            m_pend = m_pend | inv;
         end
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = mem_word(base + 32'(4 * b));
         inv            = (b == inv_beat) || (rnd_inv && ($urandom_range(0, 15) == 0));
         bus.invalidate = inv;
         if (b == rst_beat) begin
            bus.rden       = 1'b0;
            bus.invalidate = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            check_val("rst_mem_req", 32'(bus.mem_req), 32'd0);
            check_val("rst_stall", 32'(bus.stall), 32'd0);
            check_val("rst_hit_cnt", bus.hit_cnt, 32'd0);
            check_val("rst_miss_cnt", bus.miss_cnt, 32'd0);
            model_reset();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            // Remaining beats arrive after the abort and must be ignored.
            for (int r = b; r < 8; r++) begin
               bus.mem_rvalid = 1'b1;
               bus.mem_rdata  = $urandom;
               @(negedge clk);
               check_val("stray_stall", 32'(bus.stall), 32'd0);
               check_val("stray_mem_req", 32'(bus.mem_req), 32'd0);
               @(posedge clk);
               #1;
            end
            bus.mem_rvalid = 1'b0;
            aborted = 1'b1;
            return;
         end
         @(negedge clk);
         check_val("beat_mem_req", 32'(bus.mem_req), 32'd0);
         check_val("beat_stall", 32'(bus.stall), 32'd1);
         @(posedge clk);
         #1;
         m_pend = m_pend | inv;
      end
      // UPDATE cycle
      bus.mem_rvalid = 1'($urandom_range(0, 1));
      inv            = rnd_inv && ($urandom_range(0, 15) == 0);
      bus.invalidate = inv;
      @(negedge clk);
      check_val("upd_stall", 32'(bus.stall), 32'd1);
      check_val("upd_mem_req", 32'(bus.mem_req), 32'd0);
      check_val("upd_hit", 32'(bus.hit), 32'd0);
      @(posedge clk);
      #1;
      m_valid[m_set][m_victim] = 1'b1;
      m_tag[m_set][m_victim]   = m_vtag;
      stamp++;
      m_use[m_set][m_victim]   = stamp;
      if (m_pend || inv) model_clear_valid();
      m_pend         = 1'b0;
      bus.invalidate = 1'b0;
      bus.mem_rvalid = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] pc, input int ack_dly, input int gap);
      bit missed;
      bit ab;
      drive_idle(pc, 1'b1, 1'b0, missed);
      if (missed) refill(ack_dly, gap, -1, -1, 1'b0, ab);
   endtask

   initial begin
      bit missed;
      bit ab;
      bus.pc         = '0;
      bus.rden       = 1'b0;
      bus.invalidate = 1'b0;
      bus.mem_ack    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check_val("rst_state_stall", 32'(bus.stall), 32'd0);
      check_val("rst_state_hit", 32'(bus.hit), 32'd0);
      check_val("rst_state_mem_req", 32'(bus.mem_req), 32'd0);
      check_val("rst_state_mem_addr", bus.mem_addr, 32'd0);
      check_val("rst_state_instr", bus.instr, EXP_NOP);
      check_val("rst_state_hit_cnt", bus.hit_cnt, 32'd0);
      check_val("rst_state_miss_cnt", bus.miss_cnt, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Cold miss of line 0, ack after two cycles, back-to-back beats.
      drive_idle(32'h0, 1'b1, 1'b0, missed);
      refill(2, 0, -1, -1, 1'b0, ab);
      drive_idle(32'h0, 1'b1, 1'b0, missed);
      drive_idle(32'h1C, 1'b1, 1'b0, missed);
      check_val("cold_instr_last", mem_word(32'h1C), 32'hA7);
      check_val("cold_miss_cnt", bus.miss_cnt, 32'd1);

      // Same-set conflict: 0x400 must evict 0x200, not the recently hit 0x000.
      fetch(32'h200, 1, 0);
      fetch(32'h000, 1, 0);
      fetch(32'h400, 1, 0);
      fetch(32'h000, 1, 0);
      fetch(32'h200, 1, 0);
      check_val("plru_miss_cnt", bus.miss_cnt, 32'd4);

      // Backpressure: slow ack, one idle cycle between beats; read every word.
      fetch(32'h820, 5, 1);
      for (int o = 0; o < 8; o++) drive_idle(32'h820 + 32'(4 * o), 1'b1, 1'b0, missed);

      // Invalidate during beat 3: line completes but is discarded.
      do_reset();
      drive_idle(32'h0, 1'b1, 1'b0, missed);
      refill(1, 0, 3, -1, 1'b0, ab);
      drive_idle(32'h0, 1'b1, 1'b0, missed);
      refill(0, 0, -1, -1, 1'b0, ab);
      check_val("inval_miss_cnt", bus.miss_cnt, 32'd2);

      // Reset during beat 4, then RDEN=0 on a missing PC.
      do_reset();
      drive_idle(32'h0, 1'b1, 1'b0, missed);
      refill(1, 0, -1, 4, 1'b0, ab);
      drive_idle(32'h0, 1'b0, 1'b0, missed);
      drive_idle(32'h600, 1'b0, 1'b0, missed);
      fetch(32'h0, 0, 0);
      check_val("post_rst_miss_cnt", bus.miss_cnt, 32'd1);

      // Randomized traffic with random invalidates and memory timing.
      for (int n = 0; n < 1500; n++) begin
         drive_idle(rand_pc(), ($urandom_range(0, 7) != 0), ($urandom_range(0, 40) == 0), missed);
         if (missed) refill(int'($urandom_range(0, 4)), -1, -1, -1, 1'b1, ab);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
